// File: rtl/fleet_pkg.sv
// Shared ship-type encoding, fleet composition and FSM states for the fleet placement controller.
package fleet_pkg;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        SUBMARINO    = 3'd0,
        CRUZADOR     = 3'd1,
        HIDROAVIAO   = 3'd2,
        ENCOURACADO  = 3'd3,
        PORTA_AVIOES = 3'd4
    } ship_t;

    localparam ship_t LAST_TYPE = PORTA_AVIOES;

    // Ships of each type in one fleet, indexed by ship_t.
    localparam logic [CNT_W-1:0] FLEET_COUNT [5] = '{3'd5, 3'd2, 3'd2, 3'd1, 3'd1};

    typedef enum logic [3:0] {
        IDLE,
        DIR,
        ORIENT,
        SET_X,
        SET_Y,
        VALIDATE,
        STORE,
        NEXT,
        DONE
    } state_t;

    function automatic logic [CNT_W-1:0] fleet_count(input ship_t t);
        return (t > LAST_TYPE) ? CNT_W'(1) : FLEET_COUNT[t];
    endfunction

endpackage

// File: rtl/fleet_counter.sv
// Tracks ship-of-type count, current ship type and current player; advances once per step.
module fleet_counter #(
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned PW        = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_step,
    output logic [2:0]    o_tipo,
    output logic [PW-1:0] o_jogador,
    output logic          o_last_ship_c,
    output logic          o_last_player_c
);
    import fleet_pkg::*;

    ship_t            r_tipo;
    logic [CNT_W-1:0] r_count;
    logic [PW-1:0]    r_jogador;
    logic             w_type_full;

    assign w_type_full     = (r_count + CNT_W'(1)) == fleet_count(r_tipo);
    assign o_last_ship_c   = w_type_full && (r_tipo == LAST_TYPE);
    assign o_last_player_c = r_jogador == PW'(N_PLAYERS - 1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tipo    <= SUBMARINO;
            r_count   <= '0;
            r_jogador <= '0;
        end else if (i_step) begin
            if (!w_type_full) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= '0;
                if (r_tipo == LAST_TYPE) begin
                    r_tipo    <= SUBMARINO;
                    r_jogador <= o_last_player_c ? '0 : r_jogador + PW'(1);
                end else begin
                    r_tipo <= ship_t'(r_tipo + 3'd1);
                end
            end
        end
    end

    assign o_tipo    = r_tipo;
    assign o_jogador = r_jogador;

endmodule

// File: rtl/fleet_placement_ctrl.sv
// Sequences every player through placing a full fleet, manually or from the random source.
// Optional validator watchdog enabled by defining PLACE_TIMEOUT_EN.
module fleet_placement_ctrl #(
    parameter int unsigned BOARD_N   = 8,
    parameter int unsigned COORD_W   = 3,
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned TIMEOUT   = 15,
    localparam int unsigned PW       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               enter,
    input  logic               select,
    input  logic               mode,
    input  logic [COORD_W-1:0] rand_pos,
    input  logic [2:0]         rand_dir,
    input  logic               val_ack,
    input  logic               val_conflict,
    output logic               val_req,
    output logic               store_we,
    output logic [2:0]         tipo,
    output logic [PW-1:0]      jogador,
    output logic [COORD_W-1:0] X1,
    output logic [COORD_W-1:0] Y1,
    output logic               direcao,
    output logic [1:0]         orientacao,
    output logic               ready,
    output logic               err_timeout
);
    import fleet_pkg::*;

    state_t             r_state;
    logic               r_val_req;
    logic               r_store_we;
    logic               r_direcao;
    logic [1:0]         r_orient;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_ready;

    logic               w_auto;
    logic               w_step;
    logic               w_last_ship;
    logic               w_last_player;
    logic               w_timeout;
    logic [2:0]         w_tipo;
    logic [PW-1:0]      w_jogador;
    logic [COORD_W-1:0] w_rand_coord;

    function automatic logic [COORD_W-1:0] coord_inc(input logic [COORD_W-1:0] c);
        return (c >= COORD_W'(BOARD_N - 1)) ? '0 : c + COORD_W'(1);
    endfunction

    assign w_auto       = (w_jogador != '0) && !mode;
    assign w_rand_coord = COORD_W'(32'(rand_pos) % BOARD_N);
    assign w_step       = enable && (r_state == NEXT);

    fleet_counter #(
        .N_PLAYERS (N_PLAYERS),
        .PW        (PW)
    ) u_counter (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_step          (w_step),
        .o_tipo          (w_tipo),
        .o_jogador       (w_jogador),
        .o_last_ship_c   (w_last_ship),
        .o_last_player_c (w_last_player)
    );

`ifdef PLACE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err_timeout;

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

    // Counts enabled VALIDATE cycles without an ack; clears whenever VALIDATE is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else if (enable) begin
            if (r_state == VALIDATE && !val_ack) begin
                if (w_timeout) begin
                    r_to_cnt      <= '0;
                    r_err_timeout <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^32'(TIMEOUT);
    assign err_timeout      = 1'b0;
`endif

    // Placement FSM with registered candidate and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_val_req  <= 1'b0;
            r_store_we <= 1'b0;
            r_direcao  <= 1'b0;
            r_orient   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_ready    <= 1'b0;
        end else if (!enable) begin
            r_store_we <= 1'b0;
        end else begin
            r_store_we <= 1'b0;
            case (r_state)
                IDLE: r_state <= DIR;
                DIR: begin
                    if (w_auto) begin
                        r_direcao <= rand_dir[0];
                        r_state   <= ORIENT;
                    end else if (enter) begin
                        r_state <= ORIENT;
                    end else if (select) begin
                        r_direcao <= ~r_direcao;
                    end
                end
                ORIENT: begin
                    if (w_auto) begin
                        r_orient <= rand_dir[2:1];
                        r_state  <= SET_X;
                    end else if (enter) begin
                        r_state <= SET_X;
                    end else if (select) begin
                        r_orient <= r_orient + 2'd1;
                    end
                end
                SET_X: begin
                    if (w_auto) begin
                        r_x     <= w_rand_coord;
                        r_state <= SET_Y;
                    end else if (enter) begin
                        r_state <= SET_Y;
                    end else if (select) begin
                        r_x <= coord_inc(r_x);
                    end
                end
                SET_Y: begin
                    if (w_auto || enter) begin
                        if (w_auto) begin
                            r_y <= w_rand_coord;
                        end
                        r_state   <= VALIDATE;
                        r_val_req <= 1'b1;
                    end else if (select) begin
                        r_y <= coord_inc(r_y);
                    end
                end
                VALIDATE: begin
                    if (val_ack) begin
                        r_val_req <= 1'b0;
                        if (val_conflict) begin
                            r_state <= SET_X;
                        end else begin
                            r_state    <= STORE;
                            r_store_we <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_val_req <= 1'b0;
                        r_state   <= SET_X;
                    end
                end
                // A freeze during STORE swallows the strobe, so it is re-issued on resume.
                STORE: begin
                    if (r_store_we) begin
                        r_state <= NEXT;
                    end else begin
                        r_store_we <= 1'b1;
                    end
                end
                NEXT: begin
                    if (w_last_ship && w_last_player) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= DIR;
                    end
                end
                DONE:    r_ready <= 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign val_req    = r_val_req;
    assign store_we   = r_store_we;
    assign tipo       = w_tipo;
    assign jogador    = w_jogador;
    assign X1         = r_x;
    assign Y1         = r_y;
    assign direcao    = r_direcao;
    assign orientacao = r_orient;
    assign ready      = r_ready;

endmodule

// File: tb/tb_fleet_placement_ctrl.sv
// Directed bench for fleet_placement_ctrl: queued store expectations checked by a store_we monitor,
// plus direct checks of reset, field editing, conflict, freeze, auto mode and completion.
module tb_fleet_placement_ctrl;

    localparam int unsigned BOARD_N   = 8;
    localparam int unsigned COORD_W   = 3;
    localparam int unsigned N_PLAYERS = 2;
    localparam int unsigned TIMEOUT   = 15;
    localparam int unsigned PW        = 1;

    logic               clk = 1'b0;
    logic               reset, enable, enter, select, mode, val_ack, val_conflict;
    logic [COORD_W-1:0] rand_pos;
    logic [2:0]         rand_dir;
    logic               val_req, store_we, direcao, ready, err_timeout;
    logic [2:0]         tipo;
    logic [PW-1:0]      jogador;
    logic [COORD_W-1:0] X1, Y1;
    logic [1:0]         orientacao;

    typedef struct packed {
        logic [PW-1:0]      jog;
        logic [2:0]         tipo;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               dir;
        logic [1:0]         ori;
    } store_t;

    store_t sb[$];
    int n_cmp    = 0;
    int n_bad    = 0;
    int n_stores = 0;

    // Bench model of the candidate and of fleet progress.
    logic [COORD_W-1:0] m_x, m_y;
    logic               m_dir;
    logic [1:0]         m_ori;
    int                 m_jog, m_tipo, m_cnt;
    int                 cnt_tab [5] = '{5, 2, 2, 1, 1};
    int                 exp_x   [4] = '{7, 0, 1, 2};
    logic [COORD_W-1:0] pos_tab [10] = '{3'd0, 3'd7, 3'd2, 3'd6, 3'd1, 3'd4, 3'd3, 3'd5, 3'd7, 3'd2};
    logic [2:0]         dir_tab [10] = '{3'b000, 3'b111, 3'b010, 3'b101, 3'b110, 3'b001, 3'b011, 3'b100, 3'b000, 3'b111};

    fleet_placement_ctrl #(
        .BOARD_N   (BOARD_N),
        .COORD_W   (COORD_W),
        .N_PLAYERS (N_PLAYERS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .enter        (enter),
        .select       (select),
        .mode         (mode),
        .rand_pos     (rand_pos),
        .rand_dir     (rand_dir),
        .val_ack      (val_ack),
        .val_conflict (val_conflict),
        .val_req      (val_req),
        .store_we     (store_we),
        .tipo         (tipo),
        .jogador      (jogador),
        .X1           (X1),
        .Y1           (Y1),
        .direcao      (direcao),
        .orientacao   (orientacao),
        .ready        (ready),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // Store monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        store_t act;
        store_t exp;
        if (store_we) begin
            act = {jogador, tipo, X1, Y1, direcao, orientacao};
            n_stores++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL store_unexpected: got payload %h, none expected", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL store_payload: got %h, expected %h", act, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic pulse_select();
        select = 1'b1;
        tick();
        select = 1'b0;
    endtask

    function automatic logic [COORD_W-1:0] inc_c(input logic [COORD_W-1:0] c);
        return (int'(c) == BOARD_N - 1) ? '0 : c + 1'b1;
    endfunction

    task automatic wait_val_req(input int budget);
        int n;
        n = 0;
        while (!val_req && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (!val_req) begin
            n_bad++;
            $display("FAIL val_req_wait: val_req=%0b after %0d cycles, expected 1", val_req, n);
        end
    endtask

    // Queue the expected store, accept the candidate, then run through STORE and NEXT.
    task automatic accept();
        sb.push_back({PW'(m_jog), 3'(m_tipo), m_x, m_y, m_dir, m_ori});
        val_ack      = 1'b1;
        val_conflict = 1'b0;
        tick();
        val_ack = 1'b0;
        check("store_latency", store_we, 1);
        tick();
        tick();
        m_cnt++;
        if (m_cnt == cnt_tab[m_tipo]) begin
            m_cnt = 0;
            if (m_tipo == 4) begin
                m_tipo = 0;
                m_jog  = m_jog + 1;
            end else begin
                m_tipo++;
            end
        end
    endtask

    task automatic place_manual(input int nd, input int no, input int nx, input int ny);
        repeat (nd) begin pulse_select(); m_dir = ~m_dir; end
        pulse_enter();
        repeat (no) begin pulse_select(); m_ori = m_ori + 2'd1; end
        pulse_enter();
        repeat (nx) begin pulse_select(); m_x = inc_c(m_x); end
        pulse_enter();
        repeat (ny) begin pulse_select(); m_y = inc_c(m_y); end
        pulse_enter();
        check("val_req_manual", val_req, 1);
        accept();
    endtask

    initial begin
        logic [2:0] d;
        reset = 1'b1; enable = 1'b0; enter = 1'b0; select = 1'b0; mode = 1'b1;
        val_ack = 1'b0; val_conflict = 1'b0; rand_pos = '0; rand_dir = '0;
        m_x = '0; m_y = '0; m_dir = 1'b0; m_ori = '0; m_jog = 0; m_tipo = 0; m_cnt = 0;
        repeat (3) tick();
        check("rst_val_req", val_req, 0);
        check("rst_store_we", store_we, 0);
        check("rst_tipo", tipo, 0);
        check("rst_jogador", jogador, 0);
        check("rst_xy", {X1, Y1}, 0);
        check("rst_dir_ori", {direcao, orientacao}, 0);
        check("rst_ready", ready, 0);
        check("rst_err_timeout", err_timeout, 0);
        reset = 1'b0;
        tick();
        enable = 1'b1;
        tick();

        // First P0 ship: field editing, wrap, enter priority, conflict and freeze.
        pulse_select(); m_dir = 1'b1;
        check("dir_toggle", direcao, 1);
        pulse_enter();
        repeat (3) pulse_select();
        m_ori = 2'd3;
        check("orient_inc", orientacao, 3);
        pulse_enter();
        repeat (6) pulse_select();
        check("x_to_6", X1, 6);
        for (int i = 0; i < 4; i++) begin
            pulse_select();
            check("x_wrap", X1, exp_x[i]);
        end
        pulse_enter();
        repeat (5) pulse_select();
        check("y_to_5", Y1, 5);
        enter = 1'b1; select = 1'b1;
        tick();
        enter = 1'b0; select = 1'b0;
        check("enter_wins_y", Y1, 5);
        check("val_req_entry", val_req, 1);
        val_ack = 1'b1; val_conflict = 1'b1;
        tick();
        val_ack = 1'b0; val_conflict = 1'b0;
        check("conflict_val_req", val_req, 0);
        check("conflict_store_we", store_we, 0);
        check("conflict_x", X1, 2);
        check("conflict_y", Y1, 5);
        check("conflict_dir_ori", {direcao, orientacao}, 3'b111);
        pulse_select();
        check("conflict_in_set_x", X1, 3);
        m_x = 3'd3; m_y = 3'd5;
        pulse_enter();
        pulse_enter();
        check("revalidate_req", val_req, 1);
        enable = 1'b0; val_ack = 1'b1;
        tick();
        val_ack = 1'b0;
        repeat (2) tick();
        check("freeze_val_req", val_req, 1);
        check("freeze_store_we", store_we, 0);
        enable = 1'b1;
        accept();

        // Stray ack outside VALIDATE must not produce a store.
        val_ack = 1'b1;
        tick();
        val_ack = 1'b0;
        check("stray_ack_store", store_we, 0);

        for (int s = 1; s < 11; s++) begin
            place_manual(s % 2, s % 4, s % 3 + 1, (s * 3) % 5);
        end
        check("p0_stores", n_stores, 11);
        check("p0_next_jogador", jogador, 1);
        check("p0_next_tipo", tipo, 0);

        // P1 in auto mode; held select must be ignored.
        mode = 1'b0; rand_pos = 3'd5; rand_dir = 3'b101; select = 1'b1;
        repeat (3) tick();
        check("auto_not_yet", val_req, 0);
        tick();
        select = 1'b0;
        check("auto_4_cycles", val_req, 1);
        check("auto_dir", direcao, 1);
        check("auto_ori", orientacao, 2);
        check("auto_x", X1, 5);
        check("auto_y", Y1, 5);
        m_dir = 1'b1; m_ori = 2'd2; m_x = 3'd5; m_y = 3'd5;
        accept();
        for (int s = 0; s < 10; s++) begin
            d        = dir_tab[s];
            rand_dir = d;
            rand_pos = pos_tab[s];
            m_dir    = d[0];
            m_ori    = d[2:1];
            m_x      = pos_tab[s];
            m_y      = pos_tab[s];
            wait_val_req(20);
            accept();
        end
        check("done_ready", ready, 1);
        check("done_jogador", jogador, 0);
        check("done_tipo", tipo, 0);
        check("total_stores", n_stores, 22);
        mode = 1'b1;
        pulse_enter();
        pulse_select();
        tick();
        check("done_sticky", ready, 1);
        check("done_no_req", val_req, 0);
        check("queue_drained", sb.size(), 0);

        // Reset while a request is outstanding.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        repeat (4) pulse_enter();
        check("pre_reset_req", val_req, 1);
        reset = 1'b1;
        tick();
        check("midrst_val_req", val_req, 0);
        check("midrst_jogador", jogador, 0);
        check("midrst_tipo", tipo, 0);
        check("midrst_ready", ready, 0);
        reset = 1'b0;
        tick();
        repeat (4) pulse_enter();
        check("wd_entry_req", val_req, 1);
`ifdef PLACE_TIMEOUT_EN
        repeat (14) tick();
        check("wd_before_req", val_req, 1);
        check("wd_before_err", err_timeout, 0);
        tick();
        check("wd_fire_req", val_req, 0);
        check("wd_fire_err", err_timeout, 1);
        pulse_select();
        check("wd_in_set_x", X1, 1);
`else
        repeat (20) tick();
        check("no_wd_req", val_req, 1);
        check("no_wd_err", err_timeout, 0);
`endif
        check("no_store_after", n_stores, 22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
